ssd1306_byte_sequencer: RTL

- Sits directly upstream of the SPI shift register.
- Takes a stream of display bytes tagged command/data over a valid/ready interface.
- Runs the SSD1306 hardware-reset power-up sequence, frames bytes with chip-select and D/C#, and issues one start pulse per byte to the shift register.
- Keeps CS asserted across back-to-back bytes and releases it after an idle timeout.

---
 rtl/ssd1306_byte_sequencer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/ssd1306_byte_sequencer.sv
// SSD1306 byte sequencer: power-up reset sequence, CS/DC framing and one start pulse per byte.
// Optional OLED_SEQ_BYTE_COUNT_EN adds a 16-bit byte_count_out of bytes handed to the shift register.
module ssd1306_byte_sequencer #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned RESET_CYCLES   = 10,
  parameter int unsigned WAKE_CYCLES    = 100,
  parameter int unsigned CS_IDLE_CYCLES = 4
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             byte_valid_in,
  input  logic [WIDTH-1:0] byte_data_in,
  input  logic             byte_dc_in,
  output logic             byte_ready_out,
  output logic             init_done_out,
  output logic             sr_start_out,
  output logic [WIDTH-1:0] sr_data_out,
  input  logic             sr_ready_in,
  output logic             oled_cs_n_out,
  output logic             oled_dc_out,
  output logic             oled_res_n_out
`ifdef OLED_SEQ_BYTE_COUNT_EN
  ,
  output logic [15:0]      byte_count_out
`endif
);

  localparam int unsigned MAX_RW  = (RESET_CYCLES > WAKE_CYCLES) ? RESET_CYCLES : WAKE_CYCLES;
  localparam int unsigned CNT_MAX = (MAX_RW > CS_IDLE_CYCLES) ? MAX_RW : CS_IDLE_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_RESET_HOLD,
    S_RESET_WAIT,
    S_IDLE,
    S_SETUP,
    S_START,
    S_BUSY,
    S_GAP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [WIDTH-1:0] lat_data;
  logic             xfer;
  logic             hold_done;
  logic             wake_done;
  logic             idle_done;

  // One shared saturating counter serves the reset, wake and CS idle timers.
  assign cnt_inc   = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
  assign hold_done = (32'(cnt) + 32'd1) >= RESET_CYCLES;
  assign wake_done = (32'(cnt) + 32'd1) >= WAKE_CYCLES;
  assign idle_done = (32'(cnt) + 32'd1) >= CS_IDLE_CYCLES;
  assign xfer      = byte_valid_in & byte_ready_out;

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state          <= S_RESET_HOLD;
      cnt            <= '0;
      lat_data       <= '0;
      oled_res_n_out <= 1'b0;
      oled_cs_n_out  <= 1'b1;
      oled_dc_out    <= 1'b0;
      sr_start_out   <= 1'b0;
      sr_data_out    <= '0;
      byte_ready_out <= 1'b0;
      init_done_out  <= 1'b0;
    end else begin
      case (state)
        S_RESET_HOLD: begin
          if (hold_done) begin
            state          <= S_RESET_WAIT;
            cnt            <= '0;
            oled_res_n_out <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_RESET_WAIT: begin
          if (wake_done) begin
            state          <= S_IDLE;
            cnt            <= '0;
            init_done_out  <= 1'b1;
            byte_ready_out <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_IDLE: begin
          if (xfer) begin
            state          <= S_SETUP;
            lat_data       <= byte_data_in;
            oled_dc_out    <= byte_dc_in;
            oled_cs_n_out  <= 1'b0;
            byte_ready_out <= 1'b0;
          end
        end
        S_SETUP: begin
          state        <= S_START;
          sr_start_out <= 1'b1;
          sr_data_out  <= lat_data;
        end
        // Start stays high until the shift register is seen idle.
        S_START: begin
          if (sr_ready_in) begin
            state        <= S_BUSY;
            sr_start_out <= 1'b0;
          end
        end
        S_BUSY: begin
          if (sr_ready_in) begin
            state          <= S_GAP;
            cnt            <= '0;
            byte_ready_out <= 1'b1;
          end
        end
        // A transfer takes priority over the CS idle timeout.
        S_GAP: begin
          if (xfer) begin
            lat_data       <= byte_data_in;
            cnt            <= '0;
            byte_ready_out <= 1'b0;
            if (byte_dc_in == oled_dc_out) begin
              state        <= S_START;
              sr_start_out <= 1'b1;
              sr_data_out  <= byte_data_in;
            end else begin
              state       <= S_SETUP;
              oled_dc_out <= byte_dc_in;
            end
          end else if (idle_done) begin
            state         <= S_IDLE;
            cnt           <= '0;
            oled_cs_n_out <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state <= S_RESET_HOLD;
        end
      endcase
    end
  end

`ifdef OLED_SEQ_BYTE_COUNT_EN
  // Counts bytes handed to the shift register; wraps naturally at 16 bits.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      byte_count_out <= '0;
    end else if ((state == S_START) && sr_ready_in) begin
      byte_count_out <= byte_count_out + 16'd1;
    end
  end
`endif

endmodule
